matrix_addr_gen: RTL

Parametrised matrix address sequencer for a ROWS x COLS matrix. It is the successor to the square DIM x DIM direction/address generator. It adds rectangular dimensions, four scan modes, an explicit start/busy/done handshake, and optional looping. It feeds the read/write address port of the matrix memory, which is 32x32 in the full design, and tells downstream logic when a whole frame has been scanned.

---
 rtl/matrix_addr_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/matrix_addr_gen.sv
// Matrix address sequencer: scans a ROWS x COLS matrix in one of four orders
// with a start/busy/done handshake and optional automatic restart.
module matrix_addr_gen #(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1,
    parameter int AW   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          loop,
    input  logic          ena,
    output logic          busy,
    output logic          valid,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [AW-1:0] addr,
    output logic          flag,
    output logic          done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [RW-1:0] ROW_MAX     = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX     = CW'(COLS - 1);
    localparam logic [AW-1:0] ADDR_MAX    = AW'(ROWS * COLS - 1);
    localparam logic [AW-1:0] ADDR_ONE    = AW'(1);
    localparam logic [AW-1:0] ADDR_STRIDE = AW'(COLS);
    // Serpentine ends on the right edge for an odd row count, left edge otherwise.
    localparam logic [CW-1:0] SERP_END_COL = (ROWS % 2 == 1) ? COL_MAX : '0;

    state_t        state;
    logic [1:0]    mode_q;
    logic          is_last;
    logic [RW-1:0] nrow;
    logic [CW-1:0] ncol;
    logic [AW-1:0] naddr;

    function automatic logic [RW+CW+AW-1:0] first_elem(input logic [1:0] m);
        return (m == 2'd2) ? {ROW_MAX, COL_MAX, ADDR_MAX} : '0;
    endfunction

    assign busy  = (state == RUN);
    assign valid = busy & ena;
    assign flag  = valid & is_last;

    always_comb begin
        is_last = 1'b0;
        case (mode_q)
            2'd2:    is_last = (row == '0) && (col == '0);
            2'd3:    is_last = (row == ROW_MAX) && (col == SERP_END_COL);
            default: is_last = (row == ROW_MAX) && (col == COL_MAX);
        endcase
    end

    // Successor element; address tracks row*COLS+col with +-1 / +-COLS steps only.
    always_comb begin
        nrow  = row;
        ncol  = col;
        naddr = addr;
        case (mode_q)
            2'd0: begin
                naddr = addr + ADDR_ONE;
                if (col == COL_MAX) begin
                    ncol = '0;
                    nrow = row + RW'(1);
                end else begin
                    ncol = col + CW'(1);
                end
            end
            2'd1: begin
                if (row == ROW_MAX) begin
                    nrow  = '0;
                    ncol  = col + CW'(1);
                    naddr = AW'(ncol);
                end else begin
                    nrow  = row + RW'(1);
                    naddr = addr + ADDR_STRIDE;
                end
            end
            2'd2: begin
                naddr = addr - ADDR_ONE;
                if (col == '0) begin
                    ncol = COL_MAX;
                    nrow = row - RW'(1);
                end else begin
                    ncol = col - CW'(1);
                end
            end
            default: begin
                if ((!row[0] && col == COL_MAX) || (row[0] && col == '0)) begin
                    nrow  = row + RW'(1);
                    naddr = addr + ADDR_STRIDE;
                end else if (!row[0]) begin
                    ncol  = col + CW'(1);
                    naddr = addr + ADDR_ONE;
                end else begin
                    ncol  = col - CW'(1);
                    naddr = addr - ADDR_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mode_q <= 2'd0;
            row    <= '0;
            col    <= '0;
            addr   <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state             <= RUN;
                        mode_q            <= mode;
                        {row, col, addr}  <= first_elem(mode);
                    end
                end
                default: begin
                    if (ena) begin
                        if (is_last) begin
                            done             <= 1'b1;
                            {row, col, addr} <= first_elem(mode_q);
                            if (!loop)
                                state <= IDLE;
                        end else begin
                            row  <= nrow;
                            col  <= ncol;
                            addr <= naddr;
                        end
                    end
                end
            endcase
        end
    end

endmodule
